normalize16: RTL and testbench
==============================

NORMALIZE16 -- requirements
Module: normalize16

Interface
REQ-001 No parameters: datapath width fixed at 16 bits; stage count fixed at 2.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_in_valid  input  1  upstream presents a sample.
REQ-005 io_in_ready  output  1  block accepts a sample this cycle.
REQ-006 io_in_bits  input  16  two's-complement signed sample.
REQ-007 io_out_valid  output  1  normalized result available.
REQ-008 io_out_ready  input  1  downstream accepts result this cycle.
REQ-009 io_out_mant  output  16  magnitude left-shifted so bit 15 is set (0 when zero).
REQ-010 io_out_lz  output  4  leading-zero count of the magnitude, i.e. the applied left shift (0 when zero).
REQ-011 io_out_sign  output  1  sign of the input sample.
REQ-012 io_out_zero  output  1  input sample was exactly 0.

Function
REQ-013 Transfers: input on io_in_valid && io_in_ready; output on io_out_valid && io_out_ready.
REQ-014 Pipeline enable en = !io_out_valid || io_out_ready; io_in_ready SHALL equal en. This is a combinational ready path, accepted by design.
REQ-015 Stage 1, when en: s1_valid <= io_in_valid; s1_sign <= io_in_bits[15]; s1_mag <= |io_in_bits| as 16-bit unsigned; s1_zero <= (io_in_bits == 0).
REQ-016 Magnitude of 0x8000 SHALL be 0x8000 (unsigned, no saturation).
REQ-017 Stage 2, when en: io_out_valid <= s1_valid; lz = leading-zero count of s1_mag; io_out_mant <= s1_mag << lz truncated to 16 bits; io_out_lz <= lz.
REQ-018 If s1_zero, stage 2 SHALL register io_out_mant = 0 and io_out_lz = 0, overriding the counter's value of 15; io_out_zero <= s1_zero.
REQ-019 io_out_sign and io_out_zero SHALL be registered in stage 2 alongside io_out_mant.
REQ-020 Latency: exactly 2 cycles from input transfer to io_out_valid when io_out_ready stays high.
REQ-021 Throughput: one sample per cycle with no bubbles while io_out_ready = 1.
REQ-022 While en = 0, all stage registers SHALL hold; no sample is lost, duplicated or reordered.
REQ-023 If io_out_ready = 1 and io_out_valid = 1 in the same cycle as a new input, the output transfers and the pipeline advances in that cycle.
REQ-024 Data registers SHALL not be required to change when their valid bit is 0; only the valid bits are architecturally significant.

Reset
REQ-025 When reset = 1: s1_valid = 0 and io_out_valid = 0 at the next edge. io_out_mant, io_out_lz, io_out_sign and io_out_zero SHALL all be 0.
REQ-026 Reset asserted mid-stream SHALL discard in-flight samples. io_in_ready is 1 in the first cycle after reset deasserts.
REQ-027 While reset is high, input handshakes SHALL have no effect.

Structure
REQ-028 Leading-zero count SHALL come from one instance of the existing combinational CLZ16 module (16-bit in, 4-bit out). There is no separate shared package.
REQ-029 The absolute-value logic and the shifter are inline. The shift is a 4-stage barrel shifter (8/4/2/1) controlled by the lz bits.

Verification
REQ-030 Input 0x0001, io_out_ready = 1 -> 2 cycles later: mant 0x8000, lz 15, sign 0, zero 0.
REQ-031 Input 0xFFFF (-1) -> mant 0x8000, lz 15, sign 1, zero 0. Input 0x8000 -> mant 0x8000, lz 0, sign 1.
REQ-032 Input 0x0000 -> mant 0x0000, lz 0, sign 0, zero 1. Input 0x00F3 -> mant 0xF300, lz 8.
REQ-033 Back-to-back 0x0001, 0x0010, 0x0100, with io_out_ready low for 4 cycles after the first output -> outputs held stable and io_in_ready = 0 while stalled. Then lz 15, 11, 7 are delivered in order with none lost.
REQ-034 Two samples in flight, reset pulsed for 1 cycle -> io_out_valid = 0 the next cycle, and neither sample ever appears at the output.
REQ-035 Random 10k samples with random io_out_ready -> scoreboard matches a reference model, including REQ-018 and the 0x8000 corner.

Source files
------------

// File: rtl/clz16.sv
// -----------------------------------------------------------------------------
// clz16 -- combinational 16-bit leading-zero counter.
//
// Ports:
//   data_i  in   16  value to examine
//   lz_o    out   4  number of zeros above the most significant set bit;
//                    an all-zero input reports 15 (callers treat zero apart)
// -----------------------------------------------------------------------------
module clz16 (
    input  logic [15:0] data_i,
    output logic [3:0]  lz_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        lz_o = 4'd15;
        for (int i = 0; i < 16; i++) begin
            lz_o = data_i[i] ? 4'(15 - i) : lz_o;
        end
    end

endmodule

// File: rtl/normalize16.sv
// -----------------------------------------------------------------------------
// normalize16 -- two-stage pipeline that turns a signed 16-bit sample into a
// normalized magnitude (bit 15 set), the applied shift, the sign and a zero
// flag.
//
// Ports:
//   clock         in    1  rising-edge clock
//   reset         in    1  synchronous active-high reset
//   io_in_valid   in    1  upstream presents a sample
//   io_in_ready   out   1  sample accepted this cycle (combinational, equals en)
//   io_in_bits    in   16  two's-complement sample
//   io_out_valid  out   1  normalized result available
//   io_out_ready  in    1  downstream accepts the result
//   io_out_mant   out  16  magnitude shifted left until bit 15 is set (0 for 0)
//   io_out_lz     out   4  applied left shift (0 for 0)
//   io_out_sign   out   1  sign of the sample
//   io_out_zero   out   1  sample was exactly zero
// -----------------------------------------------------------------------------
module normalize16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [15:0] io_in_bits,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [15:0] io_out_mant,
    output logic [3:0]  io_out_lz,
    output logic        io_out_sign,
    output logic        io_out_zero
);

    // Stage 1 registers
    logic        s1_valid_q;
    logic        s1_sign_q;
    logic [15:0] s1_mag_q;
    logic        s1_zero_q;

    // Stage 2 (output) registers
    logic        out_valid_q;
    logic [15:0] out_mant_q;
    logic [3:0]  out_lz_q;
    logic        out_sign_q;
    logic        out_zero_q;

    // Next-state and intermediate signals
    logic        en_s;
    logic [15:0] s1_mag_d;
    logic [3:0]  lz_s;
    logic [15:0] sh8_s;
    logic [15:0] sh4_s;
    logic [15:0] sh2_s;
    logic [15:0] sh1_s;
    logic [15:0] out_mant_d;
    logic [3:0]  out_lz_d;

    // The whole pipeline moves as one: it advances whenever the output slot
    // is empty or being drained this cycle.
    assign en_s        = !out_valid_q || io_out_ready;
    assign io_in_ready = en_s;

    clz16 u_clz (
        .data_i (s1_mag_q),
        .lz_o   (lz_s)
    );

    // Absolute value; 0x8000 wraps to itself, which is correct as unsigned.
    always_comb begin
        s1_mag_d = io_in_bits;
        if (io_in_bits[15]) begin
            s1_mag_d = ~io_in_bits + 16'd1;
        end else begin
            s1_mag_d = io_in_bits;
        end
    end

    // Barrel shifter (8/4/2/1) plus the zero override of the 15 the counter
    // reports for an all-zero magnitude.
    always_comb begin
        sh8_s      = lz_s[3] ? {s1_mag_q[7:0], 8'h00} : s1_mag_q;
        sh4_s      = lz_s[2] ? {sh8_s[11:0], 4'h0}    : sh8_s;
        sh2_s      = lz_s[1] ? {sh4_s[13:0], 2'b00}   : sh4_s;
        sh1_s      = lz_s[0] ? {sh2_s[14:0], 1'b0}    : sh2_s;
        out_mant_d = sh1_s;
        out_lz_d   = lz_s;
        if (s1_zero_q) begin
            out_mant_d = 16'h0000;
            out_lz_d   = 4'd0;
        end else begin
            out_mant_d = sh1_s;
            out_lz_d   = lz_s;
        end
    end

    // Pipeline registers: clear on reset, advance on en, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= 16'h0000;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_mant_q  <= 16'h0000;
            out_lz_q    <= 4'd0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (en_s) begin
            s1_valid_q  <= io_in_valid;
            s1_sign_q   <= io_in_bits[15];
            s1_mag_q    <= s1_mag_d;
            s1_zero_q   <= (io_in_bits == 16'h0000);
            out_valid_q <= s1_valid_q;
            out_mant_q  <= out_mant_d;
            out_lz_q    <= out_lz_d;
            out_sign_q  <= s1_sign_q;
            out_zero_q  <= s1_zero_q;
        end else begin
            s1_valid_q  <= s1_valid_q;
            s1_sign_q   <= s1_sign_q;
            s1_mag_q    <= s1_mag_q;
            s1_zero_q   <= s1_zero_q;
            out_valid_q <= out_valid_q;
            out_mant_q  <= out_mant_q;
            out_lz_q    <= out_lz_q;
            out_sign_q  <= out_sign_q;
            out_zero_q  <= out_zero_q;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_mant  = out_mant_q;
    assign io_out_lz    = out_lz_q;
    assign io_out_sign  = out_sign_q;
    assign io_out_zero  = out_zero_q;

endmodule

// File: tb/tb_normalize16.sv
// -----------------------------------------------------------------------------
// tb_normalize16 -- self-checking bench for normalize16. An arithmetic
// reference model predicts every result; a negedge process scoreboards all
// output transfers, the ready rule, stall stability and reset behaviour.
// Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_normalize16;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_bits;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [15:0] io_out_mant;
    logic [3:0]  io_out_lz;
    logic        io_out_sign;
    logic        io_out_zero;

    typedef struct packed {
        logic [15:0] mant;
        logic [3:0]  lz;
        logic        sign;
        logic        zero;
    } res_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    normalize16 dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_mant  (io_out_mant),
        .io_out_lz    (io_out_lz),
        .io_out_sign  (io_out_sign),
        .io_out_zero  (io_out_zero)
    );

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer magnitude, doubled until it reaches 2^15.
    function automatic res_t ref_model(input logic [15:0] x);
        int   mag;
        int   n;
        res_t r;
        r.sign = x[15];
        r.zero = (x == 16'h0000);
        mag    = int'({16'h0000, x});
        if (x[15]) mag = 65536 - mag;
        if (mag == 0) begin
            r.mant = 16'h0000;
            r.lz   = 4'd0;
        end else begin
            n = 0;
            while (mag < 32768) begin
                mag = mag * 2;
                n++;
            end
            r.mant = mag[15:0];
            r.lz   = n[3:0];
        end
        return r;
    endfunction

    // Scoreboard and protocol checks, sampled mid-cycle.
    logic rst_last   = 1'b0;
    logic stall_last = 1'b0;
    res_t held       = '0;

    always @(negedge clock) begin : cmp
        res_t got;
        res_t e;
        got = {io_out_mant, io_out_lz, io_out_sign, io_out_zero};
        if (rst_last) begin
            chk_eq("reset_out_valid", 32'(io_out_valid), 32'd0);
            chk_eq("reset_out_data", 32'(got), 32'd0);
            chk_eq("reset_in_ready", 32'(io_in_ready), 32'd1);
        end else begin
            chk_eq("in_ready_rule", 32'(io_in_ready), 32'(!io_out_valid || io_out_ready));
            if (stall_last) begin
                chk_eq("stall_valid", 32'(io_out_valid), 32'd1);
                chk_eq("stall_hold", 32'(got), 32'(held));
            end
        end
        if (reset) begin
            exp_q.delete();
        end else begin
            if (io_out_valid && io_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("spurious_output", 32'(io_out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("out_result", 32'(got), 32'(e));
                end
            end
            if (io_in_valid && io_in_ready) exp_q.push_back(ref_model(io_in_bits));
        end
        stall_last = io_out_valid && !io_out_ready && !reset;
        held       = got;
        rst_last   = reset;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // One isolated sample with the output always ready: 2-cycle latency.
    task automatic directed(input logic [15:0] x, input res_t exp, input string name);
        io_in_valid = 1'b1;
        io_in_bits  = x;
        step();
        io_in_valid = 1'b0;
        chk_eq({name, "_lat1"}, 32'(io_out_valid), 32'd0);
        step();
        chk_eq({name, "_lat2"}, 32'(io_out_valid), 32'd1);
        chk_eq(name, 32'({io_out_mant, io_out_lz, io_out_sign, io_out_zero}), 32'(exp));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0]  got_lz[$];
        logic [15:0] v;

        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_bits   = 16'h0000;
        io_out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Pin the model against hand-computed values.
        chk_eq("model_0001", 32'(ref_model(16'h0001)), 32'({16'h8000, 4'd15, 1'b0, 1'b0}));
        chk_eq("model_ffff", 32'(ref_model(16'hFFFF)), 32'({16'h8000, 4'd15, 1'b1, 1'b0}));
        chk_eq("model_8000", 32'(ref_model(16'h8000)), 32'({16'h8000, 4'd0, 1'b1, 1'b0}));
        chk_eq("model_0000", 32'(ref_model(16'h0000)), 32'({16'h0000, 4'd0, 1'b0, 1'b1}));
        chk_eq("model_00f3", 32'(ref_model(16'h00F3)), 32'({16'hF300, 4'd8, 1'b0, 1'b0}));

        // Directed single samples with literal results.
        directed(16'h0001, {16'h8000, 4'd15, 1'b0, 1'b0}, "d_0001");
        directed(16'hFFFF, {16'h8000, 4'd15, 1'b1, 1'b0}, "d_ffff");
        directed(16'h8000, {16'h8000, 4'd0,  1'b1, 1'b0}, "d_8000");
        directed(16'h0000, {16'h0000, 4'd0,  1'b0, 1'b1}, "d_0000");
        directed(16'h00F3, {16'hF300, 4'd8,  1'b0, 1'b0}, "d_00f3");
        directed(16'hFF0D, {16'hF300, 4'd8,  1'b1, 1'b0}, "d_ff0d");
        step();

        // Back-to-back with a 4-cycle downstream stall after the first output.
        io_in_valid = 1'b1;
        io_in_bits  = 16'h0001;
        step();
        io_in_bits  = 16'h0010;
        step();
        io_out_ready = 1'b0;
        io_in_bits   = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_eq("stall_in_ready", 32'(io_in_ready), 32'd0);
            chk_eq("stall_mant", 32'(io_out_mant), 32'h8000);
            chk_eq("stall_lz", 32'(io_out_lz), 32'd15);
            step();
        end
        io_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (io_out_valid) got_lz.push_back(io_out_lz);
            step();
            io_in_valid = 1'b0;
        end
        chk_eq("stall_count", 32'(got_lz.size()), 32'd3);
        if (got_lz.size() == 3) begin
            chk_eq("stall_order0", 32'(got_lz[0]), 32'd15);
            chk_eq("stall_order1", 32'(got_lz[1]), 32'd11);
            chk_eq("stall_order2", 32'(got_lz[2]), 32'd7);
        end

        // Two samples in flight, then a one-cycle reset pulse.
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in_bits   = 16'h1234;
        step();
        io_in_bits   = 16'h0F00;
        step();
        io_in_valid  = 1'b0;
        #1;
        chk_eq("rst_inflight", 32'(io_out_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_eq("rst_pulse_valid", 32'(io_out_valid), 32'd0);
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_eq("rst_flushed", 32'(io_out_valid), 32'd0);
        end

        // Random traffic with corner-heavy data and random back-pressure.
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 16'h0000;
                1:       v = 16'h8000;
                2:       v = 16'h0001;
                3:       v = 16'hFFFF;
                4:       v = 16'(32'd1 << $urandom_range(0, 15));
                default: v = 16'($urandom);
            endcase
            io_in_valid  = ($urandom_range(0, 3) != 0);
            io_in_bits   = v;
            io_out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain and confirm nothing was lost.
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk_eq("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
